// File: rtl/adder_seq_chunked.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit operand pair CHUNK bits per clock, carry held in a flop.
// Latency NCH cycles from accept to out_valid; result held while out_ready=0, no new operands until drained.
module adder_seq_chunked #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("adder_seq_chunked: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             last_sl;
    logic [31:0]      off;
    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK:0]   sl_res;
    logic [WIDTH-1:0] sl_mask;

    assign accept  = in_valid && (state_q == IDLE);
    assign last_sl = (cnt_q == CW'(NCH - 1));
    assign off     = 32'(cnt_q) * CHUNK;
    assign a_sl    = CHUNK'(a_q >> off);
    assign b_sl    = CHUNK'(b_q >> off);
    assign sl_res  = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    assign sl_mask = WIDTH'({CHUNK{1'b1}}) << off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CALC;
            CALC:    if (last_sl)   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Subtract is A + ~B + 1: invert B on capture and seed the carry with 1.
    always_comb begin
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = (state_d == DONE);
        if (accept) begin
            a_d     = A;
            b_d     = sub ? ~B : B;
            carry_d = sub | cin;
            cnt_d   = '0;
        end else if (state_q == CALC) begin
            sum_d   = (sum_q & ~sl_mask) | (WIDTH'(sl_res[CHUNK-1:0]) << off);
            carry_d = sl_res[CHUNK];
            cnt_d   = cnt_q + CW'(1);
            if (last_sl) begin
                cout_d = sl_res[CHUNK];
                ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_res[CHUNK-1] != a_q[WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
